// File: rtl/d_latch_pkg.sv
// Shared constants and types for the clocked latch emulation block.
package d_latch_pkg;

  localparam int unsigned MAX_SYNC_STAGES = 3;

  // Q/H reset value, replicated to the instance width by the user.
  localparam logic Q_RST_BIT = 1'b0;

  typedef enum logic {
    LATCH_REGISTERED  = 1'b0,
    LATCH_TRANSPARENT = 1'b1
  } latch_mode_e;

endpackage

// File: rtl/d_latch_sync_chain.sv
// Parameterised flop synchronizer with asynchronous active-low clear;
// STAGES=0 is a straight wire.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic bypass_unused;
      assign bypass_unused = &{1'b0, clk, rst_n};
      assign q = d;
    end else begin : g_flops
      logic [WIDTH-1:0] stage [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/d_latch.sv
// Latch emulation built only from clk flops: a hold register H plus an
// optional combinational bypass of D while enabled.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned TRANSPARENT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB
);

  localparam latch_mode_e MODE  = (TRANSPARENT != 0) ? LATCH_TRANSPARENT : LATCH_REGISTERED;
  localparam logic [WIDTH-1:0] Q_RST = {WIDTH{Q_RST_BIT}};

  generate
    if (SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("d_latch: SYNC_STAGES must be in 0..3");
    end
  endgenerate

  logic [WIDTH-1:0] d_eff;
  logic             e_eff;
  logic [WIDTH-1:0] h;

  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_d (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (D),
    .q     (d_eff)
  );

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_e (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (E),
    .q     (e_eff)
  );

  // An unknown enable fails the equality test, so H holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= Q_RST;
    end else if (e_eff == 1'b1) begin
      h <= d_eff;
    end
  end

  // Reset overrides both the bypass and H so Q/QB are defined immediately.
  always_comb begin
    Q = h;
    if (!rst_n) begin
      Q = Q_RST;
    end else if (MODE == LATCH_TRANSPARENT && e_eff == 1'b1) begin
      Q = d_eff;
    end
  end

  assign QB = ~Q;

  a_e_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(E));

endmodule

// File: tb/tb_d_latch.sv
// Directed and randomised checks of d_latch in transparent, registered and
// synchronised-registered configurations driven from shared D/E.
module tb_d_latch;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic         e;
  logic [W-1:0] q_t1, qb_t1, q_t0, qb_t0, q_s2, qb_s2;

  int unsigned total;
  int unsigned bad;

  // reference model state for the random phase
  logic [W-1:0] m_h0, m_h2, m_d1, m_d2;
  logic         m_e1, m_e2;

  d_latch #(.WIDTH(W), .SYNC_STAGES(0), .TRANSPARENT(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .D(d), .E(e), .Q(q_t1), .QB(qb_t1)
  );

  d_latch #(.WIDTH(W), .SYNC_STAGES(0), .TRANSPARENT(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .D(d), .E(e), .Q(q_t0), .QB(qb_t0)
  );

  d_latch #(.WIDTH(W), .SYNC_STAGES(2), .TRANSPARENT(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .D(d), .E(e), .Q(q_s2), .QB(qb_s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_q(input string tag, input logic [W-1:0] q, input logic [W-1:0] qb,
                       input logic [W-1:0] exp);
    check({tag, ".q"}, q, exp);
    check({tag, ".qb"}, qb, ~exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset with D and E active
    rst_n = 1'b0; d = 4'h5; e = 1'b1;
    #1;
    chk_q("rst.t1", q_t1, qb_t1, 4'h0);
    chk_q("rst.t0", q_t0, qb_t0, 4'h0);
    chk_q("rst.s2", q_s2, qb_s2, 4'h0);
    tick();
    chk_q("rst_clk.t1", q_t1, qb_t1, 4'h0);
    chk_q("rst_clk.s2", q_s2, qb_s2, 4'h0);

    // release: transparent follows at once, registered waits for an edge
    rst_n = 1'b1;
    #1;
    chk_q("rel.t1", q_t1, qb_t1, 4'h5);
    chk_q("rel.t0", q_t0, qb_t0, 4'h0);
    chk_q("rel.s2", q_s2, qb_s2, 4'h0);
    tick();
    chk_q("edge1.t0", q_t0, qb_t0, 4'h5);
    chk_q("edge1.s2", q_s2, qb_s2, 4'h0);
    tick();
    chk_q("edge2.s2", q_s2, qb_s2, 4'h0);
    tick();
    chk_q("edge3.s2", q_s2, qb_s2, 4'h5);

    // transparency: Q tracks D, registered copy lags one edge
    tick(); d = 4'h0; #1;
    chk_q("tr0.t1", q_t1, qb_t1, 4'h0);
    chk_q("tr0.t0", q_t0, qb_t0, 4'h5);
    tick(); d = 4'hF; #1;
    chk_q("tr1.t1", q_t1, qb_t1, 4'hF);
    chk_q("tr1.t0", q_t0, qb_t0, 4'h0);
    tick(); d = 4'h0; #1;
    chk_q("tr2.t1", q_t1, qb_t1, 4'h0);
    chk_q("tr2.t0", q_t0, qb_t0, 4'hF);

    // hold: capture F, then drop E and toggle D five times
    tick(); d = 4'hF; #1;
    chk_q("hold_ld.t1", q_t1, qb_t1, 4'hF);
    tick(); e = 1'b0; d = 4'h0; #1;
    chk_q("hold0.t1", q_t1, qb_t1, 4'hF);
    chk_q("hold0.t0", q_t0, qb_t0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick(); d = ~d; #1;
      chk_q("hold.t1", q_t1, qb_t1, 4'hF);
      chk_q("hold.t0", q_t0, qb_t0, 4'hF);
    end

    // falling E keeps the last captured value, not the later D
    tick(); d = 4'h3; e = 1'b1; #1;
    chk_q("fall_ld.t1", q_t1, qb_t1, 4'h3);
    chk_q("fall_ld.t0", q_t0, qb_t0, 4'hF);
    tick(); d = 4'hC; #1;
    chk_q("fall_tr.t1", q_t1, qb_t1, 4'hC);
    chk_q("fall_tr.t0", q_t0, qb_t0, 4'h3);
    e = 1'b0; #1;
    chk_q("fall.t1", q_t1, qb_t1, 4'h3);
    chk_q("fall.t0", q_t0, qb_t0, 4'h3);
    tick(); d = 4'h9; #1;
    chk_q("fall_hold.t1", q_t1, qb_t1, 4'h3);
    chk_q("fall_hold.t0", q_t0, qb_t0, 4'h3);

    // reset asserted while enabled, released with E still high
    tick(); e = 1'b1; d = 4'h6; #1;
    chk_q("rste_pre.t1", q_t1, qb_t1, 4'h6);
    rst_n = 1'b0; #1;
    chk_q("rste.t1", q_t1, qb_t1, 4'h0);
    chk_q("rste.t0", q_t0, qb_t0, 4'h0);
    chk_q("rste.s2", q_s2, qb_s2, 4'h0);
    tick();
    chk_q("rste_clk.t1", q_t1, qb_t1, 4'h0);
    rst_n = 1'b1; #1;
    chk_q("rste_rel.t1", q_t1, qb_t1, 4'h6);
    chk_q("rste_rel.t0", q_t0, qb_t0, 4'h0);
    chk_q("rste_rel.s2", q_s2, qb_s2, 4'h0);

    // random phase against the reference model
    tick(); rst_n = 1'b0; d = 4'h0; e = 1'b0; #1;
    m_h0 = '0; m_h2 = '0; m_d1 = '0; m_d2 = '0; m_e1 = 1'b0; m_e2 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (m_e2) m_h2 = m_d2;
      m_d2 = m_d1; m_e2 = m_e1;
      m_d1 = d;    m_e1 = e;
      if (e) m_h0 = d;
      #1;
      d = W'($urandom_range(0, 15));
      e = 1'($urandom_range(0, 1));
      #1;
      chk_q("rnd.t1", q_t1, qb_t1, e ? d : m_h0);
      chk_q("rnd.t0", q_t0, qb_t0, m_h0);
      chk_q("rnd.s2", q_s2, qb_s2, m_h2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter WIDTH, default 1, data width of D, Q and QB.
REQ-002 Parameter SYNC_STAGES, default 0, number of flip-flop synchronizer stages on D and E; legal values 0..3.
REQ-003 Parameter TRANSPARENT, default 1; 1 means Q follows D combinationally while enabled, 0 means fully registered latch emulation.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all storage.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 D  input  WIDTH  data input.
REQ-008 E  input  1  latch enable, active-high.
REQ-009 Q  output  WIDTH  latch output.
REQ-010 QB  output  WIDTH  complement output.

Function
REQ-011 D_eff and E_eff SHALL be D and E delayed through SYNC_STAGES clk flops; with SYNC_STAGES=0 they are D and E directly.
REQ-012 Hold register H SHALL load D_eff on each rising clk edge where E_eff=1, and retain its value otherwise.
REQ-013 TRANSPARENT=1: Q SHALL equal D_eff while E_eff=1 (zero latency, combinational), and H while E_eff=0.
REQ-014 TRANSPARENT=0: Q SHALL equal H (one clk latency from an enabled D_eff to Q).
REQ-015 QB SHALL equal bitwise NOT Q at all times, including during reset.
REQ-016 Falling E: Q SHALL hold the value of D_eff captured at the last rising clk edge with E_eff=1; a D change between that edge and E falling is not retained.
REQ-017 E=0: any number of D changes SHALL leave Q unchanged.
REQ-018 E=1 with D stable: Q SHALL remain stable; no glitch on Q or QB from clk.
REQ-019 X/Z on E SHALL be treated as 0 for update of H (hold); simulation assertions flag it.
REQ-020 SYNC_STAGES outside 0..3 SHALL cause an elaboration error.

Reset
REQ-021 rst_n=0 SHALL immediately clear H and all synchronizer flops to 0, independent of clk.
REQ-022 While rst_n=0, Q SHALL be all-zeros and QB all-ones in both modes, overriding E and D.
REQ-023 Reset deassertion SHALL be synchronous-release safe: the first update of H occurs at the first rising clk edge after rst_n rises.
REQ-024 Reset asserted while E=1 SHALL drop Q to 0; after release with E still 1 and TRANSPARENT=1, Q SHALL follow D_eff immediately.

Structure
REQ-025 Package d_latch_pkg SHALL hold MAX_SYNC_STAGES=3 and the Q reset value constant (all-zeros).
REQ-026 One sub-module sync_chain (parameters WIDTH, STAGES; async active-low reset) SHALL implement the synchronizer, instantiated once for D and once for E.
REQ-027 No inferred level-sensitive latches; all storage SHALL be clk flip-flops.

Verification
REQ-028 Reset: rst_n=0, D=1, E=1 -> Q=0, QB=1; release with TRANSPARENT=1 -> Q=1, QB=0 without waiting for clk.
REQ-029 Transparency (TRANSPARENT=1, SYNC_STAGES=0): E=1, D toggles 0->1->0 every 10 ns -> Q tracks D each step, QB=~Q.
REQ-030 Hold: E=1, D=1, clk edge, then E=0 and D toggles 5 times -> Q stays 1, QB stays 0.
REQ-031 Registered mode (TRANSPARENT=0): E=1, D=1 -> Q=0 until the next rising clk, then Q=1.
REQ-032 Sync latency (SYNC_STAGES=2, TRANSPARENT=0): D=1 and E=1 applied -> Q=1 exactly 3 rising clk edges later.
REQ-033 Random: 100 iterations of random D, E at 10 ns with free-running clk -> Q matches reference model every cycle, QB==~Q always.
